// File: rtl/lsu_pkg.sv
// Shared types, encodings and helpers for the lsu_rmw32 load/store sequencer.
package lsu_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_ACCESS   = 2'd2;

    // One bit per byte lane touched by an access of this size at this offset.
    function automatic logic [LANES-1:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [LANES-1:0] base;
        case (size)
            SZ_B:    base = LANES'(1);
            SZ_H:    base = LANES'(3);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00) || (size == 2'd3);
    endfunction
endpackage

// File: rtl/lsu_rmw32_if.sv
// Request/response and data-memory port bundle for lsu_rmw32.
interface lsu_rmw32_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_exc;
    logic [ADDR_W-1:0] mem_read_address;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_read_exception;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_write_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_exception;

    // slave: the LSU itself; master: execute stage plus memory
    modport slave (
        input  req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
        input  rsp_ready, mem_read_data, mem_read_exception, mem_write_exception,
        output req_ready, rsp_valid, rsp_data, rsp_exc,
        output mem_read_address, mem_write_enable, mem_write_address, mem_write_data
    );
    modport master (
        output req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
        output rsp_ready, mem_read_data, mem_read_exception, mem_write_exception,
        input  req_ready, rsp_valid, rsp_data, rsp_exc,
        input  mem_read_address, mem_write_enable, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction with sign/zero extension and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] merged
);
    logic [DATA_W-1:0] rshift;
    logic [DATA_W-1:0] wshift;
    logic [LANES-1:0]  lane_en;

    assign rshift  = word >> {off, 3'b000};
    assign wshift  = wdata << {off, 3'b000};
    assign lane_en = byte_mask(size, off);

    always_comb begin
        load_val = rshift;
        case (size)
            SZ_B:    load_val = {{(DATA_W-8){sgn & rshift[7]}}, rshift[7:0]};
            SZ_H:    load_val = {{(DATA_W-16){sgn & rshift[15]}}, rshift[15:0]};
            default: load_val = rshift;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged[8*gi +: 8] = lane_en[gi] ? wshift[8*gi +: 8] : word[8*gi +: 8];
        end
    endgenerate
endmodule

// File: rtl/lsu_rmw32.sv
// Load/store sequencer with read-modify-write for sub-word stores.
// LSU_WORD_STORE_BYPASS_EN: aligned word stores skip the read and write req_wdata directly.
module lsu_rmw32
    import lsu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    lsu_rmw32_if.slave  bus
);
    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        off_reg;
    logic [1:0]        size_reg;
    logic              signed_reg;
    logic              store_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] word_reg;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic [1:0]        rsp_exc_reg, rsp_exc_next;
    logic              accept;
    logic              bypass;
    logic [DATA_W-1:0] align_word;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] merged;

    assign bus.req_ready = (state_reg == S_IDLE) && !RESET;
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef LSU_WORD_STORE_BYPASS_EN
    assign bypass = bus.req_is_store && (bus.req_size == SZ_W);
`else
    assign bypass = 1'b0;
`endif

    // Live memory data during READ, captured word during WRITE.
    assign align_word = (state_reg == S_READ) ? bus.mem_read_data : word_reg;

    lsu_lane_align u_align (
        .word     (align_word),
        .off      (off_reg),
        .size     (size_reg),
        .sgn      (signed_reg),
        .wdata    (wdata_reg),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        state_next    = state_reg;
        rsp_data_next = rsp_data_reg;
        rsp_exc_next  = rsp_exc_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    rsp_data_next = '0;
                    rsp_exc_next  = EXC_NONE;
                    if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_next   = S_RESP;
                        rsp_exc_next = EXC_MISALIGN;
                    end else if (bypass) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus.mem_read_exception) begin
                    state_next   = S_RESP;
                    rsp_exc_next = EXC_ACCESS;
                end else if (store_reg) begin
                    state_next = S_WRITE;
                end else begin
                    state_next    = S_RESP;
                    rsp_data_next = load_val;
                end
            end
            S_WRITE: begin
                state_next   = S_RESP;
                rsp_exc_next = bus.mem_write_exception ? EXC_ACCESS : EXC_NONE;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            off_reg      <= '0;
            size_reg     <= '0;
            signed_reg   <= 1'b0;
            store_reg    <= 1'b0;
            wdata_reg    <= '0;
            word_reg     <= '0;
            rsp_data_reg <= '0;
            rsp_exc_reg  <= EXC_NONE;
        end else begin
            state_reg    <= state_next;
            rsp_data_reg <= rsp_data_next;
            rsp_exc_reg  <= rsp_exc_next;
            if (accept) begin
                addr_reg   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                off_reg    <= bus.req_addr[1:0];
                size_reg   <= bus.req_size;
                signed_reg <= bus.req_signed;
                store_reg  <= bus.req_is_store;
                wdata_reg  <= bus.req_wdata;
            end
            if (state_reg == S_READ) begin
                word_reg <= bus.mem_read_data;
            end
        end
    end

    assign bus.rsp_valid         = (state_reg == S_RESP);
    assign bus.rsp_data          = rsp_data_reg;
    assign bus.rsp_exc           = rsp_exc_reg;
    assign bus.mem_read_address  = addr_reg;
    assign bus.mem_write_address = addr_reg;
    assign bus.mem_write_data    = merged;
    assign bus.mem_write_enable  = (state_reg == S_WRITE) && !bus.mem_write_exception;
endmodule

// File: doc/lsu_rmw32.md
Name: lsu_rmw32

Overview:
- Load/store sequencer directly upstream of the 32-bit data memory port; sole driver of its read-address, write-enable, write-address and write-data inputs.
- Accepts byte/half/word load and store requests from the execute stage. Performs aligned-word reads, lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Returns one response per request, with exception code.

Parameters:
- ADDR_W, 32, address width (memory port fixed at 32)
- DATA_W, 32, data word width; byte lanes = DATA_W/8 = 4

Ports:
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  loads only: sign-extend when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  32  load result (0 for stores and exceptions)
- rsp_exc  out  2  0 = none, 1 = misaligned/illegal, 2 = access fault
- mem_read_address  out  32  word-aligned address to memory (also the write target)
- mem_read_data  in  32  combinational read data from memory
- mem_read_exception  in  1  read address out of range
- mem_write_enable  out  1  one-cycle write strobe
- mem_write_address  out  32  equals mem_read_address
- mem_write_data  out  32  merged word
- mem_write_exception  in  1  write address out of range

Behaviour:
- Reset (async, RESET high): state IDLE. req_ready = 0 while RESET is high, 1 after release. rsp_valid = 0, rsp_data = 0, rsp_exc = 0, mem_write_enable = 0, address and data registers = 0.
- Reset mid-operation aborts the transaction. No write is issued and no response is produced.
- FSM states: IDLE, READ, WRITE, RESP.
- req_ready = (state == IDLE). Handshake completes on req_valid & req_ready.
- On accept, register the request. The word address {addr[31:2], 2'b00} drives mem_read_address and mem_write_address until the next accept.
- Alignment check at accept:
  - Half requires addr[0] = 0; word requires addr[1:0] = 0; size 3 is always illegal.
  - On failure go to RESP with rsp_exc = 1. No memory access, no write.
- IDLE -> READ for all aligned requests.
- READ (1 cycle):
  - mem_read_exception = 1 -> RESP with rsp_exc = 2.
  - Otherwise capture mem_read_data.
  - Load: go to RESP. rsp_data = (word >> 8*addr[1:0]) truncated to size; sign-extend if req_signed, else zero-extend. Word loads ignore req_signed.
  - Store: go to WRITE.
- WRITE (1 cycle):
  - mask = size-wide ones << 8*addr[1:0].
  - mem_write_data = (captured & ~mask) | ((req_wdata << 8*addr[1:0]) & mask).
  - mem_write_enable = !mem_write_exception.
  - Exception -> RESP with rsp_exc = 2. Otherwise RESP with rsp_exc = 0.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_exc are held stable until rsp_ready.
  - On rsp_ready go to IDLE; the next accept is possible the following cycle.
- Latency from accept cycle to rsp_valid: aligned load 2 cycles; store 3 cycles; misaligned 1 cycle.
- Throughput: one transaction in flight. No request is accepted while rsp_valid = 1.
- mem_write_enable is never high outside WRITE.

Optional Feature:
- Macro: LSU_WORD_STORE_BYPASS_EN.
- Defined: aligned word stores go IDLE -> WRITE, skipping READ; mem_write_data = req_wdata; store latency 2 cycles.
- Undefined: word stores use the full READ -> WRITE path (mask all ones). The result is identical and store latency is 3 cycles.

Decomposition:
- lsu_pkg:
  - state enum
  - size encoding constants (SZ_B/SZ_H/SZ_W)
  - exception codes (EXC_NONE/EXC_MISALIGN/EXC_ACCESS)
  - byte-mask function
- Sub-module lsu_lane_align: purely combinational.
  - Inputs: word, addr[1:0], size, signed, wdata.
  - Outputs: extracted load value, merged store word.
  - lsu_rmw32 holds the FSM and registers.

Test Plan:
- Memory word at 0x100 = 0x8899AABB; lb signed @0x103 -> rsp_data 0xFFFFFF88, rsp_exc 0, rsp_valid 2 cycles after accept.
- Same word; lhu @0x102 -> 0x00008899; lw @0x100 -> 0x8899AABB.
- sb 0x5A @0x101 over 0x8899AABB -> one write strobe, word becomes 0x88995ABB; rsp 3 cycles after accept (bypass build: word store latency 2).
- lh @0x101 and size = 3 @0x100 -> rsp_exc 1 after 1 cycle; mem_write_enable never asserted.
- Store with mem_write_exception forced 1 -> mem_write_enable stays 0, rsp_exc 2; load with mem_read_exception forced 1 -> rsp_exc 2, rsp_data 0.
- Assert RESET in WRITE state -> no write strobe, rsp_valid 0, req_ready 1 after release. Also hold rsp_ready = 0 for 5 cycles -> response stable and req_ready stays 0.
